// File: rtl/div_seq.sv
// div_seq : multi-cycle divide sequencer for the execute stage.
//
// Accepts a DIV/DIVU request, latches the operands and runs a DATA_W-step
// restoring shift-subtract divide. The result is returned as
// {remainder, quotient} with a ready flag. EX holds start_i until it has
// consumed the result. annul_i aborts a pending or running operation.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend, sampled at acceptance
//   opdata2_i     divisor, sampled at acceptance
//   start_i       request, held high until the result is consumed
//   annul_i       abort the current or pending operation
//   result_o      {remainder, quotient}
//   dbz_o         divide-by-zero flag (only with DIV_ZERO_FLAG_EN)
//   ready_o       result_o valid
//
// Build option: define DIV_ZERO_FLAG_EN to add the dbz_o output.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
`ifdef DIV_ZERO_FLAG_EN
  output logic                dbz_o,
`endif
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
  localparam logic [2*DATA_W-1:0] ZERO_2W  = {(2*DATA_W){1'b0}};

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   rem_r;      // partial remainder
  logic [DATA_W-1:0]   quo_r;      // dividend bits shifting out, quotient bits shifting in
  logic [DATA_W-1:0]   divisor_r;
  logic                neg_q_r;    // operand signs differ
  logic                neg_r_r;    // dividend was negative

  logic                accept_s;
  logic                neg_a_s;
  logic                neg_b_s;
  logic [DATA_W-1:0]   abs_a_s;
  logic [DATA_W-1:0]   abs_b_s;
  logic [DATA_W:0]     partial_s;
  logic [DATA_W:0]     diff_s;
  logic [DATA_W-1:0]   rem_step_s;
  logic [DATA_W-1:0]   quo_step_s;
  logic [DATA_W-1:0]   quo_fix_s;
  logic [DATA_W-1:0]   rem_fix_s;
  logic [2*DATA_W-1:0] result_nxt_s;
  logic                ready_nxt_s;

  assign accept_s = (state_r == ST_FREE) && start_i && !annul_i;

  // Operand conditioning: magnitudes for the unsigned core, signs kept aside.
  always_comb begin
    neg_a_s = signed_div_i & opdata1_i[DATA_W-1];
    neg_b_s = signed_div_i & opdata2_i[DATA_W-1];
    abs_a_s = neg_a_s ? (ZERO_W - opdata1_i) : opdata1_i;
    abs_b_s = neg_b_s ? (ZERO_W - opdata2_i) : opdata2_i;
  end

  // One restoring step; the shifted remainder needs one extra bit.
  always_comb begin
    partial_s = {rem_r, quo_r[DATA_W-1]};
    diff_s    = partial_s - {1'b0, divisor_r};
    if (!diff_s[DATA_W]) begin
      rem_step_s = diff_s[DATA_W-1:0];
      quo_step_s = {quo_r[DATA_W-2:0], 1'b1};
    end else begin
      rem_step_s = partial_s[DATA_W-1:0];
      quo_step_s = {quo_r[DATA_W-2:0], 1'b0};
    end
  end

  // Sign correction applied when the iteration finishes.
  always_comb begin
    quo_fix_s = neg_q_r ? (ZERO_W - quo_r) : quo_r;
    rem_fix_s = neg_r_r ? (ZERO_W - rem_r) : rem_r;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FREE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FREE: begin
        if (accept_s) begin
          state_nxt_s = (opdata2_i == ZERO_W) ? ST_BYZERO : ST_ON;
        end else begin
          state_nxt_s = ST_FREE;
        end
      end
      ST_BYZERO: begin
        state_nxt_s = annul_i ? ST_FREE : ST_END;
      end
      ST_ON: begin
        if (annul_i) begin
          state_nxt_s = ST_FREE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_END;
        end else begin
          state_nxt_s = ST_ON;
        end
      end
      ST_END: begin
        state_nxt_s = (!start_i || annul_i) ? ST_FREE : ST_END;
      end
      default: begin
        state_nxt_s = ST_FREE;
      end
    endcase
  end

  // FSM output logic: next values of the registered result and ready.
  always_comb begin
    result_nxt_s = ZERO_2W;
    ready_nxt_s  = 1'b0;
    case (state_r)
      ST_FREE: begin
        result_nxt_s = ZERO_2W;
        ready_nxt_s  = 1'b0;
      end
      ST_BYZERO: begin
        result_nxt_s = ZERO_2W;
        ready_nxt_s  = !annul_i;
      end
      ST_ON: begin
        if (!annul_i && (cnt_r == CNT_LAST)) begin
          result_nxt_s = {rem_fix_s, quo_fix_s};
          ready_nxt_s  = 1'b1;
        end else begin
          result_nxt_s = ZERO_2W;
          ready_nxt_s  = 1'b0;
        end
      end
      ST_END: begin
        if (!start_i || annul_i) begin
          result_nxt_s = ZERO_2W;
          ready_nxt_s  = 1'b0;
        end else begin
          result_nxt_s = result_o;
          ready_nxt_s  = 1'b1;
        end
      end
      default: begin
        result_nxt_s = ZERO_2W;
        ready_nxt_s  = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_o <= ZERO_2W;
      ready_o  <= 1'b0;
    end else begin
      result_o <= result_nxt_s;
      ready_o  <= ready_nxt_s;
    end
  end

  // Datapath: operand latch at acceptance, one divide step per cycle in ON.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= CNT_ZERO;
      rem_r     <= ZERO_W;
      quo_r     <= ZERO_W;
      divisor_r <= ZERO_W;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
    end else if (accept_s) begin
      cnt_r     <= CNT_ZERO;
      rem_r     <= ZERO_W;
      quo_r     <= abs_a_s;
      divisor_r <= abs_b_s;
      neg_q_r   <= neg_a_s ^ neg_b_s;
      neg_r_r   <= neg_a_s;
    end else if ((state_r == ST_ON) && !annul_i && (cnt_r != CNT_LAST)) begin
      cnt_r     <= cnt_r + CNT_ONE;
      rem_r     <= rem_step_s;
      quo_r     <= quo_step_s;
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dbz_nxt_s;

  // Divide-by-zero flag rises with ready out of BYZERO, holds in END.
  always_comb begin
    dbz_nxt_s = 1'b0;
    case (state_r)
      ST_BYZERO: dbz_nxt_s = !annul_i;
      ST_END:    dbz_nxt_s = (!start_i || annul_i) ? 1'b0 : dbz_o;
      default:   dbz_nxt_s = 1'b0;
    endcase
  end

  // Registered divide-by-zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbz_o <= 1'b0;
    end else begin
      dbz_o <= dbz_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        dbz_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  div_seq #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i), .result_o(result_o),
`ifdef DIV_ZERO_FLAG_EN
    .dbz_o(dbz_o),
`endif
    .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference using plain 64-bit arithmetic (truncating division).
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    if (sb == 0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input logic [63:0] exp, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.sgn = s; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string name);
    int n;
    logic [63:0] exp;
    @(negedge clk);
    opdata1_i = v.a; opdata2_i = v.b; signed_div_i = v.sgn;
    start_i = 1'b1; annul_i = 1'b0;
    sb_q.push_back(v.exp);
    n = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~signed_div_i;
      end
      if (ready_o) begin
        n = e;
        break;
      end
    end
    check({name, " latency"}, 64'(n), 64'(v.lat));
    if (sb_q.size() == 0) begin
      check({name, " scoreboard"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      if (n != 0) check({name, " result"}, result_o, exp);
    end
`ifdef DIV_ZERO_FLAG_EN
    if (n != 0) check({name, " dbz"}, 64'(dbz_o), 64'(v.b == 32'd0));
`endif
    // Held while start stays high.
    @(posedge clk); #1;
    check({name, " hold ready"}, 64'(ready_o), 64'd1);
    if (n != 0) check({name, " hold result"}, result_o, v.exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, " drop ready"}, 64'(ready_o), 64'd0);
    check({name, " drop result"}, result_o, 64'd0);
  endtask

  task automatic expect_quiet(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int e = 0; e < n; e++) begin
      @(posedge clk); #1;
      if (ready_o) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    start_i = 1'b0; annul_i = 1'b0;
    #12;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset dbz", 64'(dbz_o), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk(32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 34));
    vecs.push_back(mk(32'hFFFFFFF9,   32'h00000002,   1'b1, 64'hFFFFFFFF_FFFFFFFD, 34));
    vecs.push_back(mk(32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 34));
    vecs.push_back(mk(32'd5,          32'd0,          1'b0, 64'h0,                 2));
    vecs.push_back(mk(32'hFFFFFFF9,   32'd0,          1'b1, 64'h0,                 2));
    vecs.push_back(mk(32'hFFFFFFFF,   32'd1,          1'b0, 64'h00000000_FFFFFFFF, 34));
    vecs.push_back(mk(32'hFFFFFFF9,   32'd2,          1'b0, 64'h00000001_7FFFFFFC, 34));
    vecs.push_back(mk(32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 34));
    vecs.push_back(mk(32'd3,          32'd5,          1'b0, 64'h00000003_00000000, 34));
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd3;
      rs = i[0];
      vecs.push_back(mk(ra, rb, rs, model(ra, rb, rs), 34));
    end
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Annul in FREE blocks acceptance.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    expect_quiet("annul free", 40);

    // Annul during BYZERO.
    @(negedge clk);
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    expect_quiet("annul byzero", 5);

    // Annul at edge 10 of 100/7, then a fresh 9/3.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (9) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    expect_quiet("annul on", 40);
    run_vec(mk(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 34), "after annul");

    // Asynchronous reset mid-ON.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1; start_i = 1'b0;
    #1;
    check("rst on ready", 64'(ready_o), 64'd0);
    check("rst on result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34), "after rst");

    // Asynchronous reset while a result is held.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("pre rst ready", 64'(ready_o), 64'd1);
    #2 rst = 1'b1; start_i = 1'b0;
    #1;
    check("rst end ready", 64'(ready_o), 64'd0);
    check("rst end result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("post rst idle", 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
